// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arithmetic ops and iterative multiply/shift.
// A start/ready/done handshake lets the controller stall while a long op is in flight.
module alu_seq #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   oper,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         zero,
    output logic         illegal
);

    localparam int unsigned SW = $clog2(W);
    localparam logic [SW:0] CntMul = W[SW:0];
    localparam logic [SW:0] CntOne = 1;

    typedef enum logic [1:0] {StIdle, StMul, StShift} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    result_q, result_d;
    logic            overflow_q, overflow_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic            done_q, done_d;
    logic [2*W-1:0]  mcand_q, mcand_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [W-1:0]    val_q, val_d;
    logic [SW:0]     cnt_q, cnt_d;
    logic [1:0]      sop_q, sop_d;

    logic [W-1:0]    sum, diff, alu_res;
    logic            alu_ovf, alu_ill;
    logic [SW-1:0]   shamt;
    logic            is_shift;
    logic [2*W-1:0]  acc_nxt;
    logic [W-1:0]    val_nxt;

    assign shamt    = a[SW-1:0];
    assign is_shift = (oper == 4'hB) || (oper == 4'hC) || (oper == 4'hD);
    assign sum      = a + b;
    assign diff     = b - a;
    assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle results; shifts land here only when the shift amount is zero.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (oper)
            4'h0: begin
                alu_res = sum;
                alu_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            4'h1: begin
                alu_res = diff;
                alu_ovf = (b[W-1] != a[W-1]) && (diff[W-1] != b[W-1]);
            end
            4'h2: alu_res = a & b;
            4'h3: alu_res = a | b;
            4'h4: alu_res = a ^ b;
            4'h5: alu_res = a;
            4'h6: alu_res = b;
            4'h7: alu_res = {{(W-1){1'b0}}, (a == b)};
            4'h8: alu_res = {{(W-1){1'b0}}, (a == '0)};
            4'h9: alu_res = {{(W-1){1'b0}}, (b < a)};
            4'hB, 4'hC, 4'hD: alu_res = b;
            4'hE, 4'hF: alu_ill = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // sop holds oper[1:0]: 2'b11 SLL, 2'b00 SRL, 2'b01 SRA.
    always_comb begin
        case (sop_q)
            2'b11:   val_nxt = val_q << 1;
            2'b01:   val_nxt = {val_q[W-1], val_q[W-1:1]};
            default: val_nxt = val_q >> 1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        done_d     = 1'b0;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        mplier_d   = mplier_q;
        val_d      = val_q;
        cnt_d      = cnt_q;
        sop_d      = sop_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (oper == 4'hA) begin
                        state_d  = StMul;
                        mcand_d  = {{W{1'b0}}, b};
                        mplier_d = a;
                        acc_d    = '0;
                        cnt_d    = CntMul;
                    end else if (is_shift && (shamt != '0)) begin
                        state_d = StShift;
                        val_d   = b;
                        cnt_d   = {1'b0, shamt};
                        sop_d   = oper[1:0];
                    end else begin
                        result_d   = alu_res;
                        overflow_d = alu_ovf;
                        illegal_d  = alu_ill;
                        zero_d     = (alu_res == '0);
                        done_d     = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CntOne) begin
                    state_d    = StIdle;
                    result_d   = acc_nxt[W-1:0];
                    overflow_d = |acc_nxt[2*W-1:W];
                    illegal_d  = 1'b0;
                    zero_d     = (acc_nxt[W-1:0] == '0);
                    done_d     = 1'b1;
                end
            end
            StShift: begin
                val_d = val_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntOne) begin
                    state_d    = StIdle;
                    result_d   = val_nxt;
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                    zero_d     = (val_nxt == '0);
                    done_d     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            illegal_q  <= 1'b0;
            done_q     <= 1'b0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            val_q      <= '0;
            cnt_q      <= '0;
            sop_q      <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            illegal_q  <= illegal_d;
            done_q     <= done_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            mplier_q   <= mplier_d;
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            sop_q      <= sop_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign illegal  = illegal_q;

endmodule
